// File: rtl/dram_arbiter.sv
// Single-port data RAM arbiter between the DFetch read and DWriteBack write requesters.
// Optional same-address read/write bypass enabled by defining DRAM_ARB_BYPASS_EN.
module dram_arbiter #(
    parameter int unsigned A_WIDTH      = 12,
    parameter int unsigned D_WIDTH      = 8,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rd_req,
    input  logic [A_WIDTH-1:0] rd_addr,
    output logic               rd_ack,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               rd_drdy,
    input  logic               wr_req,
    input  logic [A_WIDTH-1:0] wr_addr,
    input  logic [D_WIDTH-1:0] wr_data,
    output logic               wr_ack,
    output logic               ram_ce,
    output logic               ram_we,
    output logic [A_WIDTH-1:0] ram_a,
    output logic [D_WIDTH-1:0] ram_d,
    input  logic [D_WIDTH-1:0] ram_q
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic               rd_pend_q, rd_pend_d;
    logic               byp_pend_q, byp_pend_d;
    logic [D_WIDTH-1:0] byp_data_q, byp_data_d;
    logic [D_WIDTH-1:0] rd_data_q, rd_data_d;
    logic               active_q, active_d;

    logic grant_en;
    logic starved;
    logic byp;

    // Grant decision and RAM port drive
    always_comb begin
        grant_en = active_q & ~reset;
        starved  = (starve_cnt_q == LIMIT);
`ifdef DRAM_ARB_BYPASS_EN
        byp      = rd_req & wr_req & (rd_addr == wr_addr);
`else
        byp      = 1'b0;
`endif
        rd_ack   = grant_en & rd_req & (~wr_req | starved | byp);
        wr_ack   = grant_en & wr_req & (~rd_req | ~starved | byp);
        ram_ce   = rd_ack | wr_ack;
        ram_we   = wr_ack;
        ram_a    = (rd_ack & ~wr_ack) ? rd_addr : wr_addr;
        ram_d    = wr_data;
    end

    // Read return path; reset masks a pending return in the same cycle
    always_comb begin
        rd_drdy = rd_pend_q & ~reset;
        rd_data = rd_data_q;
        if (reset) begin
            rd_data = '0;
        end else if (rd_pend_q) begin
            rd_data = byp_pend_q ? byp_data_q : ram_q;
        end
    end

    // Next-state for counters and pipeline flags
    always_comb begin
        active_d     = 1'b1;
        starve_cnt_d = starve_cnt_q;
        rd_pend_d    = rd_ack;
        byp_pend_d   = byp & rd_ack;
        byp_data_d   = wr_data;
        rd_data_d    = rd_data;
        if (!grant_en || !rd_req || rd_ack) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < LIMIT) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Grants are held off for one cycle after reset is released
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q     <= 1'b0;
            starve_cnt_q <= '0;
            rd_pend_q    <= 1'b0;
            byp_pend_q   <= 1'b0;
            byp_data_q   <= '0;
            rd_data_q    <= '0;
        end else begin
            active_q     <= active_d;
            starve_cnt_q <= starve_cnt_d;
            rd_pend_q    <= rd_pend_d;
            byp_pend_q   <= byp_pend_d;
            byp_data_q   <= byp_data_d;
            rd_data_q    <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural RAM and a read-data scoreboard.
// Runs in both DRAM_ARB_BYPASS_EN configurations.
module tb_dram_arbiter;

    logic        clk;
    logic        reset;
    logic        rd_req;
    logic [11:0] rd_addr;
    logic        rd_ack;
    logic [7:0]  rd_data;
    logic        rd_drdy;
    logic        wr_req;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        ram_ce;
    logic        ram_we;
    logic [11:0] ram_a;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q;

    logic [7:0]  mem [4096];
    logic [7:0]  shadow [logic [11:0]];
    logic [7:0]  exp_q [$];
    logic        prev_rack;
    int          checks;
    int          errors;

    dram_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_ack  (rd_ack),
        .rd_data (rd_data),
        .rd_drdy (rd_drdy),
        .wr_req  (wr_req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_ack  (wr_ack),
        .ram_ce  (ram_ce),
        .ram_we  (ram_we),
        .ram_a   (ram_a),
        .ram_d   (ram_d),
        .ram_q   (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM with registered read data
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_a] <= ram_d;
            else        ram_q      <= mem[ram_a];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] shadow_rd(input logic [11:0] a);
        return shadow.exists(a) ? shadow[a] : 8'h00;
    endfunction

    // One clock cycle: drive at negedge, check combinational and return outputs 1ns later
    task automatic step(input logic rst_i, input logic rr, input logic [11:0] ra,
                        input logic wr, input logic [11:0] wa, input logic [7:0] wd,
                        input logic e_rack, input logic e_wack, input string tag);
        logic exp_drdy;
        logic [7:0] exp_d;
        @(negedge clk);
        reset   = rst_i;
        rd_req  = rr;
        rd_addr = ra;
        wr_req  = wr;
        wr_addr = wa;
        wr_data = wd;
        #1;
        if (rst_i) exp_q.delete();
        exp_drdy = prev_rack & ~rst_i;
        chk({tag, ".rd_ack"},  32'(rd_ack),  32'(e_rack));
        chk({tag, ".wr_ack"},  32'(wr_ack),  32'(e_wack));
        chk({tag, ".ram_ce"},  32'(ram_ce),  32'(e_rack | e_wack));
        chk({tag, ".ram_we"},  32'(ram_we),  32'(e_wack));
        chk({tag, ".rd_drdy"}, 32'(rd_drdy), 32'(exp_drdy));
        if (e_wack) begin
            chk({tag, ".ram_a"}, 32'(ram_a), 32'(wa));
            chk({tag, ".ram_d"}, 32'(ram_d), 32'(wd));
        end else if (e_rack) begin
            chk({tag, ".ram_a"}, 32'(ram_a), 32'(ra));
        end
        if (exp_drdy && rd_drdy === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL %s.scoreboard: observed rd_drdy with data 0x%0h expected no return", tag, rd_data);
            end else begin
                exp_d = exp_q.pop_front();
                assert (rd_data === exp_d) else begin
                    errors++;
                    $error("FAIL %s.rd_data: observed 0x%0h expected 0x%0h", tag, rd_data, exp_d);
                end
            end
        end
        if (e_rack) exp_q.push_back((e_wack && ra == wa) ? wd : shadow_rd(ra));
        if (e_wack) shadow[wa] = wd;
        prev_rack = e_rack;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        prev_rack = 1'b0;
        reset     = 1'b1;
        rd_req    = 1'b1;
        rd_addr   = 12'h200;
        wr_req    = 1'b1;
        wr_addr   = 12'h100;
        wr_data   = 8'hEE;

        // Reset with both requests held, then the first cycle after reset
        step(1'b1, 1'b1, 12'h200, 1'b1, 12'h100, 8'hEE, 1'b0, 1'b0, "rst0");
        chk("rst0.rd_data", 32'(rd_data), 32'h0);
        step(1'b1, 1'b1, 12'h200, 1'b1, 12'h100, 8'hEE, 1'b0, 1'b0, "rst1");
        chk("rst1.rd_data", 32'(rd_data), 32'h0);
        step(1'b0, 1'b1, 12'h200, 1'b1, 12'h100, 8'hEE, 1'b0, 1'b0, "post_rst");
        chk("post_rst.rd_data", 32'(rd_data), 32'h0);
        step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, "idle0");

        // Contention: three writes then one read, twice
        step(1'b0, 1'b0, 12'h000, 1'b1, 12'h200, 8'h77, 1'b0, 1'b1, "seed");
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                step(1'b0, 1'b1, 12'h200, 1'b1, 12'h100, 8'(8'hA0 + 4 * r + i),
                     i == 3, i != 3, $sformatf("cont%0d_%0d", r, i));
            end
        end
        step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, "idle1");

        // Write then read the same address
        step(1'b0, 1'b0, 12'h000, 1'b1, 12'h010, 8'h5A, 1'b0, 1'b1, "raw_w");
        step(1'b0, 1'b1, 12'h010, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, "raw_r");
        step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, "raw_d");
        chk("raw_hold.rd_data", 32'(rd_data), 32'h5A);

        // Back-to-back reads
        step(1'b0, 1'b0, 12'h000, 1'b1, 12'h000, 8'h11, 1'b0, 1'b1, "pre0");
        step(1'b0, 1'b0, 12'h000, 1'b1, 12'h001, 8'h22, 1'b0, 1'b1, "pre1");
        step(1'b0, 1'b0, 12'h000, 1'b1, 12'h002, 8'h33, 1'b0, 1'b1, "pre2");
        step(1'b0, 1'b1, 12'h000, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, "b2b0");
        step(1'b0, 1'b1, 12'h001, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, "b2b1");
        step(1'b0, 1'b1, 12'h002, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, "b2b2");
        step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, "b2b3");

        // Reset while a read is pending
        step(1'b0, 1'b1, 12'h001, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, "pend_r");
        step(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, "pend_rst");
        chk("pend_rst.rd_data", 32'(rd_data), 32'h0);
        step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, "pend_after");
        chk("pend_after.rd_data", 32'(rd_data), 32'h0);
        step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, "idle2");

        // Simultaneous same-address write and read
`ifdef DRAM_ARB_BYPASS_EN
        step(1'b0, 1'b1, 12'h020, 1'b1, 12'h020, 8'hC3, 1'b1, 1'b1, "byp");
        step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, "byp_d");
        chk("byp.rd_data", 32'(rd_data), 32'hC3);
`else
        step(1'b0, 1'b1, 12'h020, 1'b1, 12'h020, 8'hC3, 1'b0, 1'b1, "same_w");
        step(1'b0, 1'b1, 12'h020, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, "same_r");
        step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, "same_d");
        chk("same.rd_data", 32'(rd_data), 32'hC3);
`endif
        step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, "idle3");
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
